// File: rtl/cdb_arbiter.sv
// Round-robin arbiter and registered driver for the common data bus.
// Picks one requesting FU per clock. The FU granted on the previous edge is
// masked so that a request still held high is not broadcast twice. The
// winner's payload is registered onto cdb with the on bit set.
module cdb_arbiter #(
    parameter int N_REQ     = 5,
    parameter int PAYLOAD_W = 38,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*PAYLOAD_W-1:0]   payload_in,
    input  logic                         flush,
    output logic [PAYLOAD_W:0]           cdb,
    output logic [N_REQ-1:0]             grant,
    output logic [CNT_W-1:0]             bcast_cnt
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]       ptr;
    logic [N_REQ-1:0]       last;

    logic [N_REQ-1:0]       elig_p0;
    logic [2*N_REQ-1:0]     elig_rot_p0;
    logic                   win_vld_p0;
    logic [PTR_W-1:0]       win_idx_p0;
    logic [N_REQ-1:0]       win_oh_p0;
    logic [PAYLOAD_W-1:0]   win_payload_p0;
    int                     win_sum_p0;

    // Counter increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Pointer advance past the winner, wrapping N_REQ-1 back to 0.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + PTR_W'(1);
    endfunction

    // Arbitration: rotate eligible requests so ptr sits at bit 0, take the
    // first set bit, then map the offset back to an absolute FU index.
    always_comb begin
        elig_p0        = req & ~last;
        elig_rot_p0    = {elig_p0, elig_p0} >> ptr;
        win_vld_p0     = 1'b0;
        win_sum_p0     = 0;
        win_idx_p0     = '0;
        win_oh_p0      = '0;
        win_payload_p0 = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_vld_p0 && elig_rot_p0[k]) begin
                win_vld_p0 = 1'b1;
                win_sum_p0 = int'(ptr) + k;
            end
        end
        if (win_sum_p0 >= N_REQ) begin
            win_sum_p0 = win_sum_p0 - N_REQ;
        end
        win_idx_p0 = PTR_W'(win_sum_p0);
        for (int i = 0; i < N_REQ; i++) begin
            if (win_vld_p0 && (win_idx_p0 == PTR_W'(i))) begin
                win_oh_p0[i]   = 1'b1;
                win_payload_p0 = payload_in[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    // ---- stage boundary: arbitration result registered onto the CDB ----
    // Bus, grant, mask, pointer and broadcast count update; flush or an
    // empty arbitration drives an idle bus and leaves ptr/count alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb       <= '0;
            grant     <= '0;
            last      <= '0;
            ptr       <= '0;
            bcast_cnt <= '0;
        end else if (flush || !win_vld_p0) begin
            cdb       <= '0;
            grant     <= '0;
            last      <= '0;
        end else begin
            cdb       <= {1'b1, win_payload_p0};
            grant     <= win_oh_p0;
            last      <= win_oh_p0;
            ptr       <= wrap_inc(win_idx_p0);
            bcast_cnt <= sat_inc(bcast_cnt);
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: the stimulus process runs a behavioural
// model and queues the expected bus state; a monitor compares after each edge.
module tb_cdb_arbiter;

    localparam int N   = 5;
    localparam int PW  = 38;
    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*PW-1:0]   payload_in;
    logic              flush;
    logic [PW:0]       cdb;
    logic [N-1:0]      grant;
    logic [CW-1:0]     bcast_cnt;

    typedef struct {
        logic [PW:0]  cdb;
        logic [N-1:0] grant;
        int           cnt;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_err    = 0;
    int rst_events = 0;

    // model state
    int m_ptr  = 0;
    int m_last = -1;
    int m_cnt  = 0;

    cdb_arbiter #(.N_REQ(N), .PAYLOAD_W(PW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .payload_in (payload_in),
        .flush      (flush),
        .cdb        (cdb),
        .grant      (grant),
        .bcast_cnt  (bcast_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish (checks %0d)", n_checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N*PW-1:0] rand_payload();
        logic [N*PW-1:0] p;
        for (int i = 0; i < N; i++) p[i*PW +: PW] = PW'({$urandom(), $urandom()});
        return p;
    endfunction

    // Drive one clock's inputs on the negedge and queue what the next
    // posedge must produce, following the arbitration rules directly.
    task automatic cycle(input logic [N-1:0] r, input logic f, input logic [N*PW-1:0] pl);
        exp_t e;
        int   win;
        @(negedge clk);
        req        = r;
        flush      = f;
        payload_in = pl;
        win = -1;
        if (!f) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (win < 0 && r[i] && i != m_last) win = i;
            end
        end
        e.cdb   = '0;
        e.grant = '0;
        if (win < 0) begin
            m_last = -1;
        end else begin
            e.cdb      = {1'b1, pl[win*PW +: PW]};
            e.grant[win] = 1'b1;
            m_last     = win;
            m_ptr      = (win + 1) % N;
            if (m_cnt < MAX) m_cnt++;
        end
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_last = -1;
        m_cnt  = 0;
    endtask

    // Reset mid-cycle, check outputs clear without a clock edge, release on a negedge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        rst_events++;
        #1;
        chk("async_rst_cdb", 64'(cdb), 64'd0);
        chk("async_rst_grant", 64'(grant), 64'd0);
        chk("async_rst_cnt", 64'(bcast_cnt), 64'd0);
        model_reset();
        req   = '0;
        flush = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: compare after each posedge, then re-check cdb after the
    // payload inputs have changed to confirm it is held, not re-sampled.
    initial begin
        exp_t e;
        int   rs;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e  = sb.pop_front();
                rs = rst_events;
                chk("cdb", 64'(cdb), 64'(e.cdb));
                chk("grant", 64'(grant), 64'(e.grant));
                chk("bcast_cnt", 64'(bcast_cnt), 64'(e.cnt));
                @(negedge clk);
                #1;
                if (rs == rst_events) chk("cdb_hold", 64'(cdb), 64'(e.cdb));
            end
        end
    end

    initial begin
        logic [N*PW-1:0] pl;
        rst        = 1'b0;
        req        = '0;
        flush      = 1'b0;
        payload_in = '0;
        #12;
        chk("init_cdb", 64'(cdb), 64'd0);
        chk("init_grant", 64'(grant), 64'd0);
        chk("init_cnt", 64'(bcast_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // idle after reset
        repeat (10) cycle('0, 1'b0, rand_payload());

        // single requester: MUL every other edge
        for (int c = 0; c < 5; c++) begin
            pl = rand_payload();
            pl[2*PW +: PW] = {3'b011, 3'b100, 32'h0000_002A};
            cycle(5'b00100, 1'b0, pl);
        end
        @(posedge clk);
        #2;
        chk("single_cnt3", 64'(bcast_cnt), 64'd3);
        chk("single_on", 64'(cdb), 64'({1'b1, 3'b011, 3'b100, 32'h0000_002A}));
        // reset lands while this broadcast is on the bus
        do_reset();
        repeat (10) cycle('0, 1'b0, rand_payload());

        // round-robin with all FUs requesting
        do_reset();
        repeat (10) cycle(5'b11111, 1'b0, rand_payload());

        // pointer wrap with mask: grant FU3, then FU4, FU3, FU4
        do_reset();
        cycle(5'b01000, 1'b0, rand_payload());
        repeat (3) cycle(5'b11000, 1'b0, rand_payload());

        // flush kills the edge that would grant FU0
        do_reset();
        cycle(5'b00011, 1'b1, rand_payload());
        repeat (3) cycle(5'b00011, 1'b0, rand_payload());

        // randomized traffic
        for (int c = 0; c < 300; c++) begin
            cycle(N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 7) == 0), rand_payload());
        end

        // counter saturation
        do_reset();
        repeat (20) cycle(5'b11111, 1'b0, rand_payload());
        @(posedge clk);
        #2;
        chk("sat_cnt", 64'(bcast_cnt), 64'(MAX));
        repeat (2) cycle('0, 1'b0, rand_payload());
        chk("sat_hold", 64'(bcast_cnt), 64'(MAX));

        repeat (3) @(posedge clk);
        #3;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
